// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: word/ALU encodings plus the mult/div unit's state, iteration count and HI/LO pair.
package mips_cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ALU_NONE = 2'd0,
    ALU_MULT = 2'd1,
    ALU_DIV  = 2'd2
  } mult_op_enum;

  typedef struct packed {
    logic       sign;
    logic [3:0] op;
  } aluop_struct;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_enum;

  localparam int MULDIV_DIV_ITERS = 32;

  typedef struct packed {
    word_t hi;
    word_t lo;
  } hilo_t;

endpackage

// File: rtl/exe_muldiv_div_step.sv
// One restoring-division step: compare the shifted remainder against the divisor and subtract if it fits.
module div_step
  import mips_cpu_pkg::*;
(
  input  logic [32:0] i_rem,
  input  word_t       i_divisor,
  output word_t       o_rem,
  output logic        o_qbit
);

  logic [32:0] w_diff;

  assign w_diff = i_rem - {1'b0, i_divisor};
  // A set top bit means the remainder already exceeds any 32-bit divisor; otherwise a borrow means it did not fit.
  assign o_qbit = i_rem[32] | ~w_diff[32];
  assign o_rem  = o_qbit ? w_diff[31:0] : i_rem[31:0];

endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage multi-cycle multiply/divide unit: 3-cycle MULT, 34-cycle restoring DIV, stalls the pipe while busy.
module exe_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int DIV_ITERS = MULDIV_DIV_ITERS
) (
  input  logic  cpu_clk,
  input  logic  cpu_rst,
  input  logic  start,
  input  logic  op_div,
  input  logic  sign,
  input  word_t src1,
  input  word_t src2,
  input  logic  flush,
  output logic  stall,
  output logic  done,
  output word_t hi,
  output word_t lo
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  function automatic word_t f_abs(word_t v, logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  function automatic word_t f_neg(word_t v, logic neg);
    return neg ? -v : v;
  endfunction

  muldiv_state_enum r_state;
  logic [4:0]       r_cnt;
  logic             r_done;
  word_t            r_hi, r_lo;

  word_t       r_a, r_b, r_src1, r_rem, r_quo;
  logic        r_sa, r_sb, r_op_div, r_dz;
  logic [63:0] r_prod;

  logic        w_accept;
  logic [32:0] w_rem_sh;
  word_t       w_rem_nx;
  logic        w_qbit;
  hilo_t       w_res;

  assign w_accept = (r_state == IDLE) && start && !r_done && !flush;
  assign w_rem_sh = {r_rem, r_quo[31]};

  div_step u_div_step (
    .i_rem     (w_rem_sh),
    .i_divisor (r_b),
    .o_rem     (w_rem_nx),
    .o_qbit    (w_qbit)
  );

  always_comb begin
    stall = 1'b0;
    if (!cpu_rst && !flush)
      stall = ((r_state == IDLE) && start && !r_done) || (r_state != IDLE);
  end

  always_comb begin
    w_res = '0;
    if (r_op_div) begin
      if (r_dz) begin
        w_res.hi = r_src1;
        w_res.lo = 32'hFFFF_FFFF;
      end else begin
        w_res.hi = f_neg(r_rem, r_sa);
        w_res.lo = f_neg(r_quo, r_sa ^ r_sb);
      end
    end else begin
      w_res = (r_sa ^ r_sb) ? -r_prod : r_prod;
    end
  end

  // Control: state, iteration counter, done pulse and the architectural HI/LO result.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (w_accept) begin
            r_state <= op_div ? DIV : MUL;
            r_cnt   <= '0;
          end
          MUL: r_state <= FIX;
          DIV: begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_ITER) r_state <= FIX;
          end
          FIX: begin
            r_hi    <= w_res.hi;
            r_lo    <= w_res.lo;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Datapath: operand magnitudes, product, and the shifting remainder/quotient pair.
  always_ff @(posedge cpu_clk) begin
    if (w_accept) begin
      r_a      <= f_abs(src1, sign);
      r_b      <= f_abs(src2, sign);
      r_src1   <= src1;
      r_sa     <= sign & src1[31];
      r_sb     <= sign & src2[31];
      r_op_div <= op_div;
      r_dz     <= (src2 == 32'h0);
      r_rem    <= '0;
      r_quo    <= f_abs(src1, sign);
    end else if (r_state == MUL) begin
      r_prod <= 64'(r_a) * 64'(r_b);
    end else if (r_state == DIV) begin
      r_rem <= w_rem_nx;
      r_quo <= {r_quo[30:0], w_qbit};
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed cases, flush/reset aborts, held start, and chained random ops.
module tb_exe_muldiv;

  logic        cpu_clk, cpu_rst, start, op_div, sign, flush;
  logic [31:0] src1, src2;
  logic        stall, done;
  logic [31:0] hi, lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  exe_muldiv #(.DIV_ITERS(32)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .start   (start),
    .op_div  (op_div),
    .sign    (sign),
    .src1    (src1),
    .src2    (src2),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Reference: plain integer arithmetic on the architectural operands, returns {hi, lo}.
  function automatic logic [63:0] ref_hilo(logic d, logic sg, logic [31:0] a, logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] ea, eb, p;
    if (!d) begin
      ea = sg ? {{32{a[31]}}, a} : {32'h0, a};
      eb = sg ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return p;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    x = sg ? longint'($signed(a)) : longint'({32'h0, a});
    y = sg ? longint'($signed(b)) : longint'({32'h0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op starting in the current cycle and waits (bounded) for done; leaves us 1 time unit past the edge after done.
  task automatic run_op(input logic d, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic sok, output logic [31:0] oh, output logic [31:0] ol);
    bit fin;
    fin = 0; lat = -1; sok = 1'b1; oh = 'x; ol = 'x;
    op_div = d; sign = sg; src1 = a; src2 = b; start = 1'b1;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge cpu_clk);
      if (done === 1'b1) begin
        fin = 1; lat = c; oh = hi; ol = lo;
        if (stall !== 1'b0) sok = 1'b0;
      end else if (stall !== 1'b1) begin
        sok = 1'b0;
      end
      @(posedge cpu_clk); #1;
      if (c == 0) begin
        start = 1'b0; src1 = $urandom; src2 = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0; start = 1'b0;
    @(negedge cpu_clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b want 0", stall); end
    @(posedge cpu_clk); #1;
  endtask

  task automatic test_mult();
    int lat; logic sok; logic [31:0] rh, rl;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, lat, sok, rh, rl);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mult_latency: got %0d want 3", lat); end
    n_checks++; if (sok !== 1'b1) begin n_fail++; $display("FAIL mult_stall: stall profile wrong (got %b want 1)", sok); end
    n_checks++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg3x7: got %h_%h want ffffffff_ffffffeb", rh, rl); end
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, sok, rh, rl);
    n_checks++; if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", rh, rl); end
  endtask

  task automatic test_div();
    int lat; logic sok; logic [31:0] rh, rl;
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, sok, rh, rl);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency: got %0d want 34", lat); end
    n_checks++; if (sok !== 1'b1) begin n_fail++; $display("FAIL div_stall: stall profile wrong (got %b want 1)", sok); end
    n_checks++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg7by2: got %h_%h want ffffffff_fffffffd", rh, rl); end
    run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, sok, rh, rl);
    n_checks++; if ({rh, rl} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_100by7: got %h_%h want 00000002_0000000e", rh, rl); end
    run_op(1'b1, 1'b0, 32'd100, 32'd0, lat, sok, rh, rl);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divz_latency: got %0d want 34", lat); end
    n_checks++; if ({rh, rl} !== {32'd100, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL divu_by_zero: got %h_%h want 00000064_ffffffff", rh, rl); end
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, lat, sok, rh, rl);
    n_checks++; if ({rh, rl} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL div_signed_by_zero: got %h_%h want fffffff9_ffffffff", rh, rl); end
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, sok, rh, rl);
    n_checks++; if ({rh, rl} !== {32'h0, 32'h8000_0000}) begin n_fail++; $display("FAIL div_minint_by_m1: got %h_%h want 00000000_80000000", rh, rl); end
  endtask

  task automatic test_flush();
    int lat; logic sok; logic [31:0] rh, rl, h0, l0; bit seen;
    run_op(1'b0, 1'b0, 32'd5, 32'd6, lat, sok, rh, rl);
    h0 = hi; l0 = lo; seen = 0;
    op_div = 1'b1; sign = 1'b1; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      @(negedge cpu_clk);
      if (done === 1'b1) seen = 1;
      if (c == 10) begin
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
      end
      @(posedge cpu_clk); #1;
      start = 1'b0;
    end
    flush = 1'b0;
    n_checks++; if (seen) begin n_fail++; $display("FAIL flush_no_done: got done=1 want 0"); end
    n_checks++; if ({hi, lo} !== {h0, l0}) begin n_fail++; $display("FAIL flush_hold: got %h_%h want %h_%h", hi, lo, h0, l0); end
    run_op(1'b0, 1'b1, 32'hFFFF_FFFC, 32'd5, lat, sok, rh, rl);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL flush_restart_latency: got %0d want 3", lat); end
    n_checks++; if ({rh, rl} !== ref_hilo(1'b0, 1'b1, 32'hFFFF_FFFC, 32'd5)) begin n_fail++; $display("FAIL flush_restart_result: got %h_%h", rh, rl); end
    // Flush while the MULT sits in its final cycle must suppress the write.
    h0 = hi; l0 = lo; seen = 0;
    op_div = 1'b0; sign = 1'b0; src1 = 32'd11; src2 = 32'd13; start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) flush = 1'b1;
      @(negedge cpu_clk);
      if (done === 1'b1) seen = 1;
      @(posedge cpu_clk); #1;
      start = 1'b0; flush = 1'b0;
    end
    n_checks++; if (seen || {hi, lo} !== {h0, l0}) begin n_fail++; $display("FAIL flush_in_fix: got done_seen=%0d hilo=%h_%h want 0 %h_%h", seen, hi, lo, h0, l0); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    op_div = 1'b1; sign = 1'b0; src1 = 32'd77; src2 = 32'd5; start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) cpu_rst = 1'b1;
      @(negedge cpu_clk);
      if (c == 5) begin
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall_forced: got %b want 0", stall); end
      end
      @(posedge cpu_clk); #1;
      start = 1'b0;
    end
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    n_checks++; if ({hi, lo, done, stall} !== 66'h0) begin n_fail++; $display("FAIL rst_mid_state: got hi=%h lo=%h done=%b stall=%b want all 0", hi, lo, done, stall); end
    for (int c = 0; c < 40; c++) begin
      @(negedge cpu_clk);
      if (done === 1'b1) seen = 1;
    end
    @(posedge cpu_clk); #1;
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_mid_no_done: got done=1 want 0"); end
  endtask

  task automatic test_start_held();
    bit busy;
    busy = 0;
    op_div = 1'b0; sign = 1'b0; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge cpu_clk);
      if (c == 3) begin
        n_checks++; if (done !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL held_done_cycle: got done=%b stall=%b want 1 0", done, stall); end
        n_checks++; if (lo !== 32'd81) begin n_fail++; $display("FAIL held_result: got %0d want 81", lo); end
      end
      @(posedge cpu_clk); #1;
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge cpu_clk);
      if (done === 1'b1 || stall === 1'b1) busy = 1;
    end
    @(posedge cpu_clk); #1;
    n_checks++; if (busy) begin n_fail++; $display("FAIL held_no_restart: got busy=1 want 0"); end
  endtask

  task automatic test_back_to_back_random();
    int lat; logic sok; logic [31:0] rh, rl, a, b; logic d, sg; logic [63:0] exp;
    for (int i = 0; i < 30; i++) begin
      d = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      a = pick_operand(); b = pick_operand();
      exp = ref_hilo(d, sg, a, b);
      run_op(d, sg, a, b, lat, sok, rh, rl);
      n_checks++; if (lat !== (d ? 34 : 3) || sok !== 1'b1) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d stall_ok=%b want %0d 1", i, lat, sok, d ? 34 : 3); end
      n_checks++; if ({rh, rl} !== exp) begin n_fail++; $display("FAIL rand_result[%0d] d=%b s=%b a=%h b=%h: got %h_%h want %h", i, d, sg, a, b, rh, rl, exp); end
    end
  endtask

  initial begin
    cpu_rst = 1'b1; start = 1'b1; op_div = 1'b0; sign = 1'b0; flush = 1'b0;
    src1 = 32'd3; src2 = 32'd4;
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid();
    test_start_held();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
